am2911_next_addr_ctrl: RTL

- Next-address control unit that drives the control inputs of a cascade of 4-bit microprogram sequencer slices.
- Holds the current microinstruction's sequencing fields in a pipeline register and evaluates a 16-opcode instruction set against a condition input.
- Contains the loop counter and produces the sequencer controls s1/s0, zero, cin, re, fe, pup, plus branch-address source enables.
- Sits between the microcode ROM output fields and the sequencer slices.

---
 rtl/am2911_next_addr_ctrl_if.sv | 38 +++
 rtl/am2911_next_addr_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/am2911_next_addr_ctrl_if.sv
// am2911_next_addr_ctrl_if: microinstruction fields in, sequencer controls and counter/stack status out
interface am2911_next_addr_ctrl_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 hold;
    logic [3:0]           op_in;
    logic                 ccen_in;
    logic                 pol_in;
    logic [CNT_WIDTH-1:0] d_in;
    logic                 cc;
    logic [3:0]           op_q;
    logic                 s1;
    logic                 s0;
    logic                 zero;
    logic                 cin;
    logic                 re;
    logic                 fe;
    logic                 pup;
    logic                 pl_oe;
    logic                 map_oe;
    logic                 vect_oe;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 cnt_zero;
    logic                 stk_ovf;
    logic                 stk_unf;

    modport master (
        output hold, op_in, ccen_in, pol_in, d_in, cc,
        input  op_q, s1, s0, zero, cin, re, fe, pup, pl_oe, map_oe, vect_oe,
               cnt_q, cnt_zero, stk_ovf, stk_unf
    );

    modport slave (
        input  hold, op_in, ccen_in, pol_in, d_in, cc,
        output op_q, s1, s0, zero, cin, re, fe, pup, pl_oe, map_oe, vect_oe,
               cnt_q, cnt_zero, stk_ovf, stk_unf
    );
endinterface

// File: rtl/am2911_next_addr_ctrl.sv
// am2911_next_addr_ctrl: 16-opcode next-address control for sequencer slices; NAC_STACK_TRACK_EN adds stack depth/overflow tracking
module am2911_next_addr_ctrl #(
    parameter int CNT_WIDTH = 8
) (
    input logic clock,
    input logic reset,
    am2911_next_addr_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        JZ, CJS, JMAP, CJP, PUSH, JSRP, CJV, JRP,
        RFCT, RPCT, CRTN, CJPP, LDCT, LOOP, CONT, TWB
    } opcode_t;

    opcode_t              op_q;
    logic                 ccen_q;
    logic                 pol_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 cnt_zero;
    logic                 pass;
    logic [1:0]           s;
    logic                 zero;
    logic                 cin;
    logic                 re;
    logic                 fe;
    logic                 pup;
    logic                 map_sel;
    logic                 vect_sel;
    logic                 ld;
    logic                 dec;

    assign cnt_zero = (cnt_q == '0);
    assign pass     = ccen_q ? (bus.cc ^ pol_q) : 1'b1;

    // pipeline register and loop counter; hold freezes both, reset wins over hold
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q   <= CONT;
            ccen_q <= 1'b0;
            pol_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (!bus.hold) begin
            op_q   <= opcode_t'(bus.op_in);
            ccen_q <= bus.ccen_in;
            pol_q  <= bus.pol_in;
            cnt_q  <= ld ? bus.d_in : dec ? cnt_q - CNT_WIDTH'(1) : cnt_q;
        end
    end

    // opcode decode against the live condition; hold forces a repeat of the current address
    always_comb begin
        s        = 2'b00;
        zero     = 1'b1;
        cin      = 1'b1;
        re       = 1'b1;
        fe       = 1'b1;
        pup      = 1'b0;
        map_sel  = 1'b0;
        vect_sel = 1'b0;
        ld       = 1'b0;
        dec      = 1'b0;
        if (bus.hold) begin
            cin = 1'b0;
        end else begin
            case (op_q)
                JZ:   zero = 1'b0;
                CJS: begin
                    s   = pass ? 2'b11 : 2'b00;
                    fe  = !pass;
                    pup = pass;
                end
                JMAP: begin
                    s       = 2'b11;
                    map_sel = 1'b1;
                end
                CJP:  s = pass ? 2'b11 : 2'b00;
                PUSH: begin
                    fe  = 1'b0;
                    pup = 1'b1;
                    ld  = pass;
                end
                JSRP: begin
                    s   = pass ? 2'b11 : 2'b01;
                    fe  = 1'b0;
                    pup = 1'b1;
                end
                CJV: begin
                    s        = pass ? 2'b11 : 2'b00;
                    vect_sel = pass;
                end
                JRP:  s = pass ? 2'b11 : 2'b01;
                RFCT: begin
                    s   = cnt_zero ? 2'b00 : 2'b10;
                    fe  = !cnt_zero;
                    dec = !cnt_zero;
                end
                RPCT: begin
                    s   = cnt_zero ? 2'b00 : 2'b11;
                    dec = !cnt_zero;
                end
                CRTN: begin
                    s  = pass ? 2'b10 : 2'b00;
                    fe = !pass;
                end
                CJPP: begin
                    s  = pass ? 2'b11 : 2'b00;
                    fe = !pass;
                end
                LDCT: begin
                    re = 1'b0;
                    ld = 1'b1;
                end
                LOOP: begin
                    s  = pass ? 2'b00 : 2'b10;
                    fe = !pass;
                end
                TWB: begin
                    s   = pass ? 2'b00 : cnt_zero ? 2'b11 : 2'b10;
                    fe  = !(pass || cnt_zero);
                    dec = !cnt_zero;
                end
                default: ;
            endcase
        end
    end

    assign bus.op_q     = op_q;
    assign bus.s1       = s[1];
    assign bus.s0       = s[0];
    assign bus.zero     = zero;
    assign bus.cin      = cin;
    assign bus.re       = re;
    assign bus.fe       = fe;
    assign bus.pup      = pup;
    assign bus.pl_oe    = !(map_sel || vect_sel);
    assign bus.map_oe   = map_sel;
    assign bus.vect_oe  = vect_sel;
    assign bus.cnt_q    = cnt_q;
    assign bus.cnt_zero = cnt_zero;

`ifdef NAC_STACK_TRACK_EN
    logic       push;
    logic       pop;
    logic [2:0] depth;
    logic       ovf;
    logic       unf;

    assign push = !bus.hold && !fe && pup;
    assign pop  = !bus.hold && !fe && !pup;

    // shadow of the 4-deep slice stack; depth saturates and the error flags stick until reset
    always_ff @(posedge clock) begin
        if (reset) begin
            depth <= 3'd0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (push) begin
            if (depth == 3'd4) ovf <= 1'b1;
            else depth <= depth + 3'd1;
        end else if (pop) begin
            if (depth == 3'd0) unf <= 1'b1;
            else depth <= depth - 3'd1;
        end
    end

    assign bus.stk_ovf = ovf;
    assign bus.stk_unf = unf;
`else
    assign bus.stk_ovf = 1'b0;
    assign bus.stk_unf = 1'b0;
`endif
endmodule
